irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller placed directly upstream of the processor core. It drives the core's single `interrupt` input and supplies the vector address for the program sequencer.
- Synchronises NUM_IRQ external request lines, detects rising edges, latches and masks them, and picks one by fixed priority.
- Runs a request/acknowledge/return handshake with the core. Nesting is not supported: one interrupt is serviced at a time.

Parameters:
- NUM_IRQ, 4, number of request lines (2..8).
- PMA_SIZE, 16, program-memory address width; width of int_vec.
- VEC_BASE, 16'h0008, vector address of IRQ 0.
- VEC_STRIDE, 4, address spacing between consecutive vectors.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  NUM_IRQ  asynchronous external requests; rising-edge sensitive.
- irq_mask_we  input  1  write strobe for the mask register.
- irq_mask_wdt  input  NUM_IRQ  mask write data; 1 = masked.
- irq_gen_we  input  1  write strobe for the global enable.
- irq_gen_wdt  input  1  global enable write data.
- core_ack  input  1  core has taken the vector (one-cycle pulse).
- core_rti  input  1  core executed return-from-interrupt (one-cycle pulse).
- interrupt  output  1  request to the core; high only in state REQ.
- int_vec  output  PMA_SIZE  vector address of the selected IRQ.
- irq_id  output  3  index of the selected/in-service IRQ.
- in_service  output  1  high only in state SERV.
- irq_pend  output  NUM_IRQ  latched request register, for status reads.

Behaviour:
- Reset values (registered, synchronous):
  - sync stages, edge history, irq_pend, irq_id, int_vec, interrupt, in_service = 0.
  - mask = all 1s; global enable = 0; state = IDLE.
- Synchroniser: two flops per line (s1, s2) plus a history flop s2_d. The edge term is s2 & ~s2_d.
- Latency: irq_in goes high before clock edge k → s2 is high after edge k+1 → the irq_pend bit is set at edge k+2 → interrupt rises at edge k+3, provided the line is unmasked, gen = 1 and state = IDLE.
- Latch register:
  - A bit is set by its edge term regardless of mask or gen.
  - A bit is cleared only by core_ack for the selected irq_id.
  - If set and clear hit the same bit in the same cycle, set wins (the new event is retained).
  - A level held high produces exactly one event.
- Eligibility: eligible = irq_pend & ~mask, used only when gen = 1. Priority is fixed: lowest index wins.
- Mask and gen writes take effect at the next edge. If both the mask write and the eligibility check fall in the same cycle, the eligibility check uses the old value.
- FSM:
  - IDLE: if gen && |eligible, then at the next edge: irq_id ← winning index; int_vec ← VEC_BASE + irq_id*VEC_STRIDE (truncated to PMA_SIZE, wrap-around allowed); interrupt ← 1; go to REQ. Otherwise stay.
  - REQ:
    - irq_id and int_vec are frozen.
    - Masking the selected line or clearing gen does not cancel the request.
    - A higher-priority event arriving now does not pre-empt it.
    - On core_ack: clear irq_pend[irq_id]; interrupt ← 0; in_service ← 1; go to SERV.
    - core_rti in REQ is ignored.
  - SERV:
    - New events keep latching.
    - On core_rti: in_service ← 0; go to IDLE. The next request can rise at the following edge, i.e. one idle cycle minimum between services.
    - core_ack in SERV is ignored.
- core_ack and core_rti arriving together:
  - In REQ, only the ack is acted on.
  - In SERV, only the rti is acted on.
- Reset mid-operation: all state and outputs return to their reset values at that edge. Any pending or in-service interrupt is discarded.
- irq_id is zero-extended from its index width; indices ≥ NUM_IRQ never occur.

Test Plan:
- Basic service:
  - Stimulus: reset; mask = 0, gen = 1; pulse irq_in[2] high before edge k.
  - Required: irq_pend = 4'b0100 after edge k+2; interrupt = 1, irq_id = 2, int_vec = 16'h0010 after edge k+3.
  - Then core_ack: interrupt = 0, in_service = 1, irq_pend = 0. Then core_rti: in_service = 0.
- Priority:
  - Stimulus: irq_in[3] and irq_in[1] rise in the same cycle.
  - Required: first service irq_id = 1, int_vec = 16'h000C. After rti, irq_id = 3, int_vec = 16'h0014.
- Masking:
  - Stimulus: mask = 4'b0001; raise irq_in[0].
  - Required: irq_pend[0] = 1 and interrupt stays 0. Writing mask = 0 makes interrupt rise at the next edge.
  - Also: gen = 0 blocks any request the same way.
- Set/clear collision:
  - Stimulus: re-edge irq_in[2] so its edge term lands in the same cycle as core_ack for irq 2.
  - Required: irq_pend[2] = 1 after that edge. A second service of irq 2 follows rti.
- No pre-emption:
  - Stimulus: while in REQ with irq 2, raise irq_in[0] and set mask[2] = 1.
  - Required: interrupt stays 1 with irq_id = 2. irq 0 is serviced only after rti.
- Reset mid-service:
  - Stimulus: assert reset in SERV while irq_pend = 4'b1000.
  - Required: after the edge, every output is 0, mask = 4'hF, and no interrupt follows when reset is released.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller that sits in front of the core.
// It synchronises and edge-detects the request lines and latches each event.
// It then masks the latched requests and picks the lowest eligible index.
// A request/ack/rti handshake with the core services one interrupt at a time.
module irq_ctrl #(
    parameter int                  NUM_IRQ    = 4,
    parameter int                  PMA_SIZE   = 16,
    parameter logic [PMA_SIZE-1:0] VEC_BASE   = 16'h0008,
    parameter int                  VEC_STRIDE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                irq_mask_we,
    input  logic [NUM_IRQ-1:0]  irq_mask_wdt,
    input  logic                irq_gen_we,
    input  logic                irq_gen_wdt,
    input  logic                core_ack,
    input  logic                core_rti,
    output logic                interrupt,
    output logic [PMA_SIZE-1:0] int_vec,
    output logic [2:0]          irq_id,
    output logic                in_service,
    output logic [NUM_IRQ-1:0]  irq_pend
);

    // Handshake states: waiting, request raised to the core, handler running.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;

    logic [NUM_IRQ-1:0]  r_s1;
    logic [NUM_IRQ-1:0]  r_s2;
    logic [NUM_IRQ-1:0]  r_s2_d;
    logic [NUM_IRQ-1:0]  r_pend;
    logic [NUM_IRQ-1:0]  r_mask;
    logic                r_gen;
    logic [1:0]          r_state;
    logic [2:0]          r_irq_id;
    logic [PMA_SIZE-1:0] r_int_vec;
    logic                r_interrupt;
    logic                r_in_service;

    logic [NUM_IRQ-1:0]  w_edge;
    logic [NUM_IRQ-1:0]  w_elig;
    logic                w_any;
    logic [2:0]          w_win_idx;
    logic [PMA_SIZE-1:0] w_win_vec;
    logic [NUM_IRQ-1:0]  w_clr;

    // Two-flop synchroniser per line plus a history flop for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, which is what makes this a shift chain.
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s2_d <= '0;
        end else begin
            r_s1   <= irq_in;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    // One-cycle event per synchronised rising edge; a held level fires once.
    assign w_edge = r_s2 & ~r_s2_d;

    // Lowest eligible index wins; gen gates the whole request.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_elig    = r_pend & ~r_mask;
        w_any     = r_gen && (w_elig != '0);
        w_win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_idx = 3'(i);
            end
        end
    end

    // Vector address of the winner; wraps within the program-memory width.
    assign w_win_vec = VEC_BASE + PMA_SIZE'(w_win_idx) * PMA_SIZE'(VEC_STRIDE);

    // The ack of the request in flight clears only the bit being serviced.
    assign w_clr = (r_state == ST_REQ && core_ack) ? (NUM_IRQ'(1) << r_irq_id) : '0;

    // Latched requests: a new edge overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
        end
    end

    // Software-written mask and global enable; they start fully blocked.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '1;
            r_gen  <= 1'b0;
        end else begin
            if (irq_mask_we) r_mask <= irq_mask_wdt;
            if (irq_gen_we)  r_gen  <= irq_gen_wdt;
        end
    end

    // Request/ack/rti handshake; id and vector stay frozen once a request is raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_irq_id     <= '0;
            r_int_vec    <= '0;
            r_interrupt  <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_irq_id    <= w_win_idx;
                        r_int_vec   <= w_win_vec;
                        r_interrupt <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // rti is meaningless before the core has taken the vector.
                    if (core_ack) begin
                        r_interrupt  <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= ST_SERV;
                    end
                end
                ST_SERV: begin
                    // A stray ack while the handler runs is ignored.
                    if (core_rti) begin
                        r_in_service <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_interrupt  <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign interrupt  = r_interrupt;
    assign int_vec    = r_int_vec;
    assign irq_id     = r_irq_id;
    assign in_service = r_in_service;
    assign irq_pend   = r_pend;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl with directed scenarios and random traffic.
// Each driven cycle steps an event-level reference model.
// The predicted post-edge outputs go into a queue that a separate monitor pops.
module tb_irq_ctrl;

    localparam int NUM_IRQ = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic        irq_mask_we;
    logic [3:0]  irq_mask_wdt;
    logic        irq_gen_we;
    logic        irq_gen_wdt;
    logic        core_ack;
    logic        core_rti;
    logic        interrupt;
    logic [15:0] int_vec;
    logic [2:0]  irq_id;
    logic        in_service;
    logic [3:0]  irq_pend;

    irq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .irq_mask_we  (irq_mask_we),
        .irq_mask_wdt (irq_mask_wdt),
        .irq_gen_we   (irq_gen_we),
        .irq_gen_wdt  (irq_gen_wdt),
        .core_ack     (core_ack),
        .core_rti     (core_rti),
        .interrupt    (interrupt),
        .int_vec      (int_vec),
        .irq_id       (irq_id),
        .in_service   (in_service),
        .irq_pend     (irq_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        intr;
        logic        serv;
        logic [3:0]  pend;
        logic [2:0]  id;
        logic [15:0] vec;
    } snap_t;

    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the sample history of the input lines, a set of pending
    // requests, and "which irq is being serviced, and has the core taken it".
    logic [3:0]  m_hist [3];
    logic [3:0]  m_pend;
    logic [3:0]  m_mask;
    bit          m_gen;
    int          m_cur;
    bit          m_acked;
    logic [2:0]  m_id;
    logic [15:0] m_vec;

    task automatic model_step(input bit rst, input logic [3:0] irq, input bit mwe,
                              input logic [3:0] mwdt, input bit gwe, input bit gwdt,
                              input bit ack, input bit rti);
        logic [3:0] ev;
        logic [3:0] elig;
        logic [3:0] clr;
        if (rst) begin
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            m_pend  = '0;
            m_mask  = 4'hF;
            m_gen   = 1'b0;
            m_cur   = -1;
            m_acked = 1'b0;
            m_id    = '0;
            m_vec   = '0;
        end else begin
            // A line contributes an event when its sample from two edges ago is
            // high and its sample from three edges ago is low.
            ev   = m_hist[1] & ~m_hist[2];
            elig = m_pend & ~m_mask;
            clr  = '0;
            if (m_cur < 0) begin
                if (m_gen && elig != 4'h0) begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (elig[i]) begin
                            m_cur = i;
                            break;
                        end
                    end
                    m_acked = 1'b0;
                    m_id    = 3'(m_cur);
                    m_vec   = 16'(32'h8 + 32'(m_cur) * 4);
                end
            end else if (!m_acked) begin
                if (ack) begin
                    clr[m_cur] = 1'b1;
                    m_acked    = 1'b1;
                end
            end else if (rti) begin
                m_cur = -1;
            end
            m_pend = (m_pend & ~clr) | ev;
            if (mwe) m_mask = mwdt;
            if (gwe) m_gen = gwdt;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = irq;
        end
    endtask

    // Drive one cycle after the falling edge and queue the predicted outputs.
    task automatic cyc(input bit rst, input logic [3:0] irq, input bit mwe,
                       input logic [3:0] mwdt, input bit gwe, input bit gwdt,
                       input bit ack, input bit rti);
        snap_t s;
        @(negedge clk);
        reset        = rst;
        irq_in       = irq;
        irq_mask_we  = mwe;
        irq_mask_wdt = mwdt;
        irq_gen_we   = gwe;
        irq_gen_wdt  = gwdt;
        core_ack     = ack;
        core_rti     = rti;
        model_step(rst, irq, mwe, mwdt, gwe, gwdt, ack, rti);
        s.intr = (m_cur >= 0) && !m_acked;
        s.serv = (m_cur >= 0) && m_acked;
        s.pend = m_pend;
        s.id   = m_id;
        s.vec  = m_vec;
        exp_q.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 0, 4'h0, 0, 0, 0, 0);
    endtask
    task automatic pulse(input logic [3:0] irq); cyc(0, irq, 0, 4'h0, 0, 0, 0, 0); endtask
    task automatic do_ack();                     cyc(0, 4'h0, 0, 4'h0, 0, 0, 1, 0); endtask
    task automatic do_rti();                     cyc(0, 4'h0, 0, 4'h0, 0, 0, 0, 1); endtask
    task automatic wmask(input logic [3:0] m);   cyc(0, 4'h0, 1, m, 0, 0, 0, 0);    endtask
    task automatic wgen(input bit g);            cyc(0, 4'h0, 0, 4'h0, 1, g, 0, 0); endtask
    task automatic hold(input logic [3:0] irq, input bit ack, input bit rti);
        cyc(0, irq, 0, 4'h0, 0, 0, ack, rti);
    endtask

    // Wait until just after the edge that applies the last driven cycle.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every edge, compare the DUT against the oldest prediction.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb.interrupt",  32'(interrupt),  32'(e.intr));
                check("sb.in_service", 32'(in_service), 32'(e.serv));
                check("sb.irq_pend",   32'(irq_pend),   32'(e.pend));
                check("sb.irq_id",     32'(irq_id),     32'(e.id));
                check("sb.int_vec",    32'(int_vec),    32'(e.vec));
            end
        end
    end

    initial begin
        logic [3:0] r_irq;
        reset = 1'b1; irq_in = '0; irq_mask_we = 1'b0; irq_mask_wdt = '0;
        irq_gen_we = 1'b0; irq_gen_wdt = 1'b0; core_ack = 1'b0; core_rti = 1'b0;

        // Reset state.
        cyc(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        settle();
        check("rst.interrupt", 32'(interrupt), 0);
        check("rst.in_service", 32'(in_service), 0);
        check("rst.irq_pend", 32'(irq_pend), 0);
        check("rst.irq_id", 32'(irq_id), 0);
        check("rst.int_vec", 32'(int_vec), 0);
        cyc(0, 4'h0, 1, 4'h0, 1, 1, 0, 0);

        // Basic service of irq 2: pend at k+2, request at k+3.
        pulse(4'b0100);
        idle(2);
        settle();
        check("basic.pend_k2", 32'(irq_pend), 32'h4);
        check("basic.no_req_k2", 32'(interrupt), 0);
        idle(1);
        settle();
        check("basic.interrupt", 32'(interrupt), 1);
        check("basic.irq_id", 32'(irq_id), 2);
        check("basic.int_vec", 32'(int_vec), 32'h0010);
        do_ack();
        settle();
        check("basic.ack_int", 32'(interrupt), 0);
        check("basic.ack_serv", 32'(in_service), 1);
        check("basic.ack_pend", 32'(irq_pend), 0);
        do_rti();
        settle();
        check("basic.rti_serv", 32'(in_service), 0);

        // Priority: irq 1 beats irq 3, irq 3 follows after rti.
        pulse(4'b1010);
        idle(3);
        settle();
        check("prio.first_id", 32'(irq_id), 1);
        check("prio.first_vec", 32'(int_vec), 32'h000C);
        do_ack();
        do_rti();
        settle();
        check("prio.gap", 32'(interrupt), 0);
        idle(1);
        settle();
        check("prio.second_id", 32'(irq_id), 3);
        check("prio.second_vec", 32'(int_vec), 32'h0014);
        do_ack();
        do_rti();

        // Masking with a held level: one event only.
        wmask(4'b0001);
        for (int i = 0; i < 4; i++) hold(4'b0001, 0, 0);
        settle();
        check("mask.pend", 32'(irq_pend), 32'h1);
        check("mask.blocked", 32'(interrupt), 0);
        cyc(0, 4'b0001, 1, 4'h0, 0, 0, 0, 0);
        settle();
        check("mask.old_value", 32'(interrupt), 0);
        hold(4'b0001, 0, 0);
        settle();
        check("mask.unmask_req", 32'(interrupt), 1);
        check("mask.unmask_id", 32'(irq_id), 0);
        check("mask.unmask_vec", 32'(int_vec), 32'h0008);
        hold(4'b0001, 1, 0);
        hold(4'b0001, 0, 1);
        for (int i = 0; i < 3; i++) hold(4'b0001, 0, 0);
        settle();
        check("level.one_event", 32'(irq_pend), 0);
        check("level.no_req", 32'(interrupt), 0);
        idle(1);

        // Global enable off blocks requests.
        wgen(0);
        pulse(4'b0010);
        idle(3);
        settle();
        check("gen.pend", 32'(irq_pend), 32'h2);
        check("gen.blocked", 32'(interrupt), 0);
        wgen(1);
        idle(1);
        settle();
        check("gen.req", 32'(interrupt), 1);
        check("gen.id", 32'(irq_id), 1);
        do_ack();
        do_rti();

        // Set/clear collision on irq 2.
        pulse(4'b0100);
        idle(3);
        pulse(4'b0100);
        idle(1);
        do_ack();
        settle();
        check("coll.pend_kept", 32'(irq_pend), 32'h4);
        check("coll.serv", 32'(in_service), 1);
        do_rti();
        idle(1);
        settle();
        check("coll.second_req", 32'(interrupt), 1);
        check("coll.second_id", 32'(irq_id), 2);

        // No pre-emption: irq 0 arrives and irq 2 gets masked while in REQ.
        cyc(0, 4'b0001, 1, 4'b0100, 0, 0, 0, 0);
        idle(3);
        settle();
        check("nopre.req", 32'(interrupt), 1);
        check("nopre.id", 32'(irq_id), 2);
        check("nopre.pend", 32'(irq_pend), 32'h5);
        do_ack();
        do_rti();
        idle(1);
        settle();
        check("nopre.next_id", 32'(irq_id), 0);
        check("nopre.next_vec", 32'(int_vec), 32'h0008);
        do_ack();
        do_rti();
        wmask(4'h0);

        // Reset in SERV with irq 3 pending again.
        pulse(4'b1000);
        idle(3);
        do_ack();
        pulse(4'b1000);
        idle(2);
        settle();
        check("rstmid.pend", 32'(irq_pend), 32'h8);
        check("rstmid.serv", 32'(in_service), 1);
        cyc(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        settle();
        check("rstmid.interrupt", 32'(interrupt), 0);
        check("rstmid.in_service", 32'(in_service), 0);
        check("rstmid.irq_pend", 32'(irq_pend), 0);
        check("rstmid.irq_id", 32'(irq_id), 0);
        check("rstmid.int_vec", 32'(int_vec), 0);
        idle(4);
        settle();
        check("rstmid.quiet", 32'(interrupt), 0);
        wgen(1);
        pulse(4'b0010);
        idle(5);
        settle();
        check("rstmid.mask_all", 32'(interrupt), 0);
        wmask(4'h0);
        idle(1);
        settle();
        check("rstmid.unmask_req", 32'(interrupt), 1);
        do_ack();
        do_rti();

        // Random traffic against the model.
        r_irq = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            bit       rst;
            bit       mwe;
            bit       gwe;
            logic [3:0] mwdt;
            if ($urandom_range(3) == 0) r_irq = r_irq ^ (4'h1 << $urandom_range(3));
            rst  = ($urandom_range(499) == 0);
            mwe  = ($urandom_range(15) == 0);
            mwdt = 4'($urandom) & 4'($urandom);
            gwe  = ($urandom_range(31) == 0);
            cyc(rst, r_irq, mwe, mwdt, gwe, $urandom_range(3) != 0,
                $urandom_range(3) == 0, $urandom_range(3) == 0);
        end
        idle(2);
        repeat (3) @(posedge clk);
        #3;
        check("sb.drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
